// File: rtl/bram_pkg.sv
// Package: bram_pkg
// Default geometry constants shared by the dual-port RAM and its port logic.
//   BRAM_ADDR_W : address width in bits
//   BRAM_DEPTH  : number of words (2**BRAM_ADDR_W)
//   BRAM_DATA_W : word width in bits
//   BRAM_PORTS  : number of independent access ports
package bram_pkg;
  localparam int BRAM_ADDR_W = 14;
  localparam int BRAM_DEPTH  = 16384;
  localparam int BRAM_DATA_W = 1;
  localparam int BRAM_PORTS  = 2;
endpackage : bram_pkg

// File: rtl/bram_port.sv
// Module: bram_port
// Per-port logic of the dual-port RAM: the registered read data (with
// synchronous clear) and the per-bit write enables derived from the mask.
// Ports:
//   CLK      in   clock, rising edge
//   RST      in   synchronous active-high reset, clears Q only
//   CE       in   port enable
//   WE       in   write enable
//   WEM      in   per-bit write mask (1 = write that bit)
//   addr_ok  in   address lies inside the populated depth
//   rd_word  in   raw array word at the port address (pre-write contents)
//   bit_we   out  per-bit write strobes applied to the shared array
//   Q        out  registered read data
module bram_port
  import bram_pkg::*;
#(
  parameter int DATA_W = BRAM_DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CE,
  input  logic              WE,
  input  logic [DATA_W-1:0] WEM,
  input  logic              addr_ok,
  input  logic [DATA_W-1:0] rd_word,
  output logic [DATA_W-1:0] bit_we,
  output logic [DATA_W-1:0] Q
);

  logic [DATA_W-1:0] q_reg;

  // Out-of-range addresses never write; the mask selects which bits change.
  assign bit_we = (CE && WE && addr_ok) ? WEM : '0;

  // rd_word is sampled at the same edge the array is written, so the port
  // always returns the pre-write contents (read-first). Reset wins over reads.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_reg <= '0;
    end else if (CE) begin
      q_reg <= addr_ok ? rd_word : '0;
    end
  end

  assign Q = q_reg;

endmodule : bram_port

// File: rtl/bram_16384x1.sv
// Module: bram_16384x1
// True dual-port RAM, DEPTH x DATA_W, one-cycle registered read, read-first,
// per-bit write mask, port 1 has priority on simultaneous writes to a bit.
// Ports (p = 0/1):
//   CLK   in   clock, rising edge
//   RST   in   synchronous active-high reset; clears Q0/Q1, memory untouched
//   CEp   in   port enable
//   Ap    in   address
//   Dp    in   write data
//   WEp   in   write enable
//   WEMp  in   per-bit write mask
//   Qp    out  registered read data
// Optional macro BRAM_COLLISION_CHECK_EN: simulation-only monitor that reports
// same-address accesses with at least one write and stops the simulation.
module bram_16384x1
  import bram_pkg::*;
#(
  parameter int ADDR_W = BRAM_ADDR_W,
  parameter int DEPTH  = BRAM_DEPTH,
  parameter int DATA_W = BRAM_DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CE0,
  input  logic [ADDR_W-1:0] A0,
  input  logic [DATA_W-1:0] D0,
  input  logic              WE0,
  input  logic [DATA_W-1:0] WEM0,
  output logic [DATA_W-1:0] Q0,
  input  logic              CE1,
  input  logic [ADDR_W-1:0] A1,
  input  logic [DATA_W-1:0] D1,
  input  logic              WE1,
  input  logic [DATA_W-1:0] WEM1,
  output logic [DATA_W-1:0] Q1
);

  // Shared storage; the declaration initialiser gives all-zero contents in
  // both simulation and the bitstream.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic              ce_arr      [BRAM_PORTS];
  logic              we_arr      [BRAM_PORTS];
  logic [ADDR_W-1:0] addr_arr    [BRAM_PORTS];
  logic [DATA_W-1:0] wem_arr     [BRAM_PORTS];
  logic [DATA_W-1:0] rd_word_arr [BRAM_PORTS];
  logic [DATA_W-1:0] bit_we_arr  [BRAM_PORTS];
  logic [DATA_W-1:0] q_arr       [BRAM_PORTS];
  logic              addr_ok_arr [BRAM_PORTS];

  assign ce_arr[0]   = CE0;
  assign we_arr[0]   = WE0;
  assign addr_arr[0] = A0;
  assign wem_arr[0]  = WEM0;
  assign ce_arr[1]   = CE1;
  assign we_arr[1]   = WE1;
  assign addr_arr[1] = A1;
  assign wem_arr[1]  = WEM1;
  assign Q0          = q_arr[0];
  assign Q1          = q_arr[1];

  genvar gi;
  generate
    for (gi = 0; gi < BRAM_PORTS; gi++) begin : g_port
      // Range check only exists when the depth leaves unused addresses.
      if (DEPTH < (2 ** ADDR_W)) begin : g_partial
        assign addr_ok_arr[gi] = ({1'b0, addr_arr[gi]} < (ADDR_W + 1)'(DEPTH));
      end else begin : g_full
        assign addr_ok_arr[gi] = 1'b1;
      end

      assign rd_word_arr[gi] = mem[addr_arr[gi]];

      bram_port #(
        .DATA_W (DATA_W)
      ) u_port (
        .CLK     (CLK),
        .RST     (RST),
        .CE      (ce_arr[gi]),
        .WE      (we_arr[gi]),
        .WEM     (wem_arr[gi]),
        .addr_ok (addr_ok_arr[gi]),
        .rd_word (rd_word_arr[gi]),
        .bit_we  (bit_we_arr[gi]),
        .Q       (q_arr[gi])
      );
    end
  endgenerate

  // Both ports write from one process so the array has a single driver.
  // Port 1 is applied last, so it wins on every bit it masks in; bits only
  // port 0 masks in take port 0's data. Writes are not gated by reset.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DATA_W; i++) begin
      if (bit_we_arr[0][i]) begin
        mem[addr_arr[0]][i] <= D0[i];
      end
      if (bit_we_arr[1][i]) begin
        mem[addr_arr[1]][i] <= D1[i];
      end
    end
  end

`ifdef BRAM_COLLISION_CHECK_EN
`ifndef SYNTHESIS
  always @(posedge CLK) begin
    if (CE0 && CE1 && (WE0 || WE1) && (A0 == A1)) begin
      $error("%m: port collision at address 0x%0h", A0);
      $finish;
    end
  end
`endif
`endif

endmodule : bram_16384x1

// File: tb/tb_bram_16384x1.sv
// Testbench for bram_16384x1: directed vectors, expected read data pushed into
// per-port queues tagged with the clock edge that produces it; a monitor pops
// and compares after each edge.
module tb_bram_16384x1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce0 = 1'b0, we0 = 1'b0;
  logic        ce1 = 1'b0, we1 = 1'b0;
  logic [13:0] a0 = '0, a1 = '0;
  logic [0:0]  d0 = '0, d1 = '0, wem0 = '0, wem1 = '0;
  logic [0:0]  q0, q1;

  typedef struct {
    int    at_edge;
    logic  exp;
    string name;
  } exp_t;

  exp_t  exp_q0 [$];
  exp_t  exp_q1 [$];
  exp_t  e0, e1;
  int    edge_cnt = 0;
  int    n_tests  = 0;
  int    n_fail   = 0;
  bit    stim_done = 1'b0;
  bit    chk_done  = 1'b0;

  always #5 clk = ~clk;

  bram_16384x1 dut (
    .CLK  (clk),
    .RST  (rst),
    .CE0  (ce0),
    .A0   (a0),
    .D0   (d0),
    .WE0  (we0),
    .WEM0 (wem0),
    .Q0   (q0),
    .CE1  (ce1),
    .A1   (a1),
    .D1   (d1),
    .WE1  (we1),
    .WEM1 (wem1),
    .Q1   (q1)
  );

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: compares every expectation whose edge has passed.
  always @(negedge clk) begin
    while (exp_q0.size() != 0 && exp_q0[0].at_edge <= edge_cnt) begin
      e0 = exp_q0.pop_front();
      n_tests++;
      if (q0 !== e0.exp) begin
        n_fail++;
        $display("FAIL %s port0 edge %0d: got %b expected %b", e0.name, e0.at_edge, q0, e0.exp);
      end
    end
    while (exp_q1.size() != 0 && exp_q1[0].at_edge <= edge_cnt) begin
      e1 = exp_q1.pop_front();
      n_tests++;
      if (q1 !== e1.exp) begin
        n_fail++;
        $display("FAIL %s port1 edge %0d: got %b expected %b", e1.name, e1.at_edge, q1, e1.exp);
      end
    end
    if (stim_done && !chk_done) begin
      n_tests++;
      if (exp_q0.size() + exp_q1.size() != 0) begin
        n_fail++;
        $display("FAIL drain: got %0d unchecked entries expected 0", exp_q0.size() + exp_q1.size());
      end
      chk_done = 1'b1;
    end
  end

  // One clock cycle of stimulus; kN/eN request a check of QN after this edge.
  task automatic cyc(input logic r,
                     input logic c0, input logic [13:0] ad0, input logic w0, input logic dd0, input logic m0,
                     input logic c1, input logic [13:0] ad1, input logic w1, input logic dd1, input logic m1,
                     input logic k0, input logic x0, input logic k1, input logic x1, input string nm);
    exp_t t;
    rst = r;
    ce0 = c0; a0 = ad0; we0 = w0; d0 = dd0; wem0 = m0;
    ce1 = c1; a1 = ad1; we1 = w1; d1 = dd1; wem1 = m1;
    t.at_edge = edge_cnt + 1;
    t.name    = nm;
    if (k0) begin t.exp = x0; exp_q0.push_back(t); end
    if (k1) begin t.exp = x1; exp_q1.push_back(t); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    cyc(1, 0,14'h0000,0,0,0, 0,14'h0000,0,0,0, 1,0,1,0, "reset_q");
    cyc(1, 0,14'h0000,0,0,0, 0,14'h0000,0,0,0, 1,0,1,0, "reset_q2");

    // Basic write then cross-port read
    cyc(0, 1,14'h0005,1,1,1, 0,14'h0000,0,0,0, 1,0,0,0, "wr5_old");
    cyc(0, 0,14'h0000,0,0,0, 1,14'h0005,0,0,0, 0,0,1,1, "basic_rd5");

    // Write mask
    cyc(0, 0,14'h0000,0,0,0, 1,14'h3FFF,0,0,0, 0,0,1,0, "init_3fff");
    cyc(0, 1,14'h3FFF,1,1,0, 0,14'h0000,0,0,0, 1,0,0,0, "mask0_wr");
    cyc(0, 0,14'h0000,0,0,0, 1,14'h3FFF,0,0,0, 0,0,1,0, "mask0_rd");
    cyc(0, 1,14'h3FFF,1,1,1, 0,14'h0000,0,0,0, 1,0,0,0, "mask1_wr");
    cyc(0, 0,14'h0000,0,0,0, 1,14'h3FFF,0,0,0, 0,0,1,1, "mask1_rd");

    // Read-first, own port and cross port
    cyc(0, 1,14'h0100,1,1,1, 1,14'h0100,0,0,0, 1,0,1,0, "rdfirst");
    cyc(0, 1,14'h0100,0,0,0, 1,14'h0100,0,0,0, 1,1,1,1, "rdfirst_re");

    // Disabled port must not write
    cyc(0, 0,14'h0003,1,1,1, 0,14'h0000,0,0,0, 0,0,0,0, "ce0_off_wr");
    cyc(0, 1,14'h0003,0,0,0, 0,14'h0000,0,0,0, 1,0,0,0, "ce0_off_rd");

    // Hold and reset
    cyc(0, 1,14'h0001,1,1,1, 0,14'h0000,0,0,0, 0,0,0,0, "wr1");
    cyc(0, 0,14'h0000,0,0,0, 1,14'h0001,0,0,0, 0,0,1,1, "hold_rd1");
    for (int i = 0; i < 3; i++)
      cyc(0, 0,14'h0000,0,0,0, 0,14'h0000,0,0,0, 0,0,1,1, "hold");
    cyc(1, 1,14'h0002,1,1,1, 0,14'h0000,0,0,0, 1,0,1,0, "rst_clear");
    cyc(0, 1,14'h0002,0,0,0, 1,14'h0001,0,0,0, 1,1,1,1, "post_rst");

    // Dual write to the same address
    cyc(0, 1,14'h2000,1,0,1, 1,14'h2000,1,1,1, 1,0,1,0, "dual_wr");
    cyc(0, 1,14'h2000,0,0,0, 0,14'h0000,0,0,0, 1,1,0,0, "dual_p1wins");
    cyc(0, 1,14'h2000,1,0,1, 1,14'h2000,1,1,0, 1,1,1,1, "dual_mask");
    cyc(0, 0,14'h0000,0,0,0, 1,14'h2000,0,0,0, 0,0,1,0, "dual_p0bits");

    // Clear scratch locations, then mark address 0
    cyc(0, 1,14'h0005,1,0,1, 1,14'h0100,1,0,1, 1,1,1,1, "clr_a");
    cyc(0, 1,14'h0001,1,0,1, 1,14'h0002,1,0,1, 1,1,1,1, "clr_b");
    cyc(0, 1,14'h0000,1,1,1, 0,14'h0000,0,0,0, 1,0,0,0, "wr0");

    // Sweep all addresses: only 0x0000 and 0x3FFF hold 1
    for (int i = 0; i < 8192; i++)
      cyc(0, 1,14'(i),0,0,0, 1,14'(i + 8192),0,0,0,
          1, logic'(i == 0), 1, logic'(i + 8192 == 16383), "sweep");

    cyc(0, 0,14'h0000,0,0,0, 0,14'h0000,0,0,0, 0,0,0,0, "idle");
    cyc(0, 0,14'h0000,0,0,0, 0,14'h0000,0,0,0, 0,0,0,0, "idle");
    stim_done = 1'b1;
    for (int i = 0; i < 10 && !chk_done; i++) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_bram_16384x1

// File: doc/bram_16384x1.md
BRAM_16384X1 -- requirements
Module: bram_16384x1

Interface
REQ-001 Parameter ADDR_W, default 14, SHALL set the address width in bits.
REQ-002 Parameter DEPTH, default 16384 (2**ADDR_W), SHALL set the number of words.
REQ-003 Parameter DATA_W, default 1, SHALL set the word width; WEM is per-bit, so its width equals DATA_W.
REQ-004 CLK  input  1  SHALL be the single clock; all logic is on the rising edge.
REQ-005 RST  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 CE0  input  1  SHALL be the port-0 enable.
REQ-007 A0  input  ADDR_W  SHALL be the port-0 address.
REQ-008 D0  input  DATA_W  SHALL be the port-0 write data.
REQ-009 WE0  input  1  SHALL be the port-0 write enable.
REQ-010 WEM0  input  DATA_W  SHALL be the port-0 per-bit write mask; 1 = write that bit.
REQ-011 Q0  output  DATA_W  SHALL be the port-0 registered read data.
REQ-012 CE1, A1, D1, WE1, WEM1, Q1 SHALL be identical to the port-0 signals, for port 1.

Function
REQ-013 The block SHALL be a true dual-port memory of DEPTH x DATA_W bits; both ports read and write independently in the same cycle.
REQ-014 Port p SHALL write on a rising edge only when CEp=1 and WEp=1.
- Each bit i with WEMp[i]=1 SHALL take Dp[i].
- Bits with WEMp[i]=0 SHALL stay unchanged.
REQ-015 Read latency SHALL be 1 cycle: when CEp=1 at edge N, Qp SHALL show mem[Ap] from edge N on.
REQ-016 The read SHALL happen in every enabled cycle, including write cycles.
REQ-017 Read mode SHALL be read-first: a port writing address X SHALL return the pre-write contents of X on its Qp.
REQ-018 When CEp=0, Qp SHALL hold its last value; the memory is unchanged.
REQ-019 Cross-port, same address, one port writing: the reading port SHALL return the old (pre-write) data.
REQ-020 Both ports writing the same address in the same cycle: port 1 SHALL win on every bit where WEM1=1; on the other bits, port 0's masked bits SHALL apply.
REQ-021 Addresses SHALL be fully decoded. With the default parameters no out-of-range address exists; with non-power-of-two DEPTH, writes to addresses >= DEPTH SHALL be ignored and reads from them SHALL return 0.

Reset
REQ-022 While RST=1 at a rising edge, Q0 and Q1 SHALL be cleared to 0.
REQ-023 RST SHALL take priority over reads on that edge.
REQ-024 RST SHALL NOT clear memory contents; writes presented in a reset cycle SHALL still be performed.
REQ-025 Initial memory contents SHALL be 0 in simulation and in the FPGA bitstream.

Configuration
REQ-026 Macro BRAM_COLLISION_CHECK_EN SHALL control a simulation-only collision monitor.
- When defined: at every rising edge where CE0=CE1=1, (WE0|WE1)=1 and A0==A1, the monitor SHALL print an error naming the instance and the address, then call $finish.
- When undefined: no monitor logic is compiled, and behaviour follows REQ-019/REQ-020.
- The monitor SHALL be excluded from synthesis in both cases.

Structure
REQ-027 Package bram_pkg SHALL hold the default constants BRAM_ADDR_W=14, BRAM_DEPTH=16384 and BRAM_DATA_W=1.
REQ-028 The storage SHALL be one array inferable as FPGA block RAM (RAMB36 true dual-port).
REQ-029 A sub-module bram_port SHALL hold the per-port read register, reset and mask logic; the top SHALL instantiate it twice around the shared array.

Verification
REQ-030 Basic write/read: port 0 writes A0=0x0005, D0=1, WEM0=1; port 1 reads 0x0005 on the next cycle -> Q1=1 one cycle later.
REQ-031 Write mask: mem[0x3FFF]=0; write D0=1 with WEM0=0 -> a later read of 0x3FFF returns 0; repeat with WEM0=1 -> returns 1.
REQ-032 Read-first: mem[0x0100]=0; port 0 writes 1 to 0x0100 while port 1 reads 0x0100 in the same cycle -> Q0=0 and Q1=0 that cycle; re-read -> 1.
REQ-033 Hold and reset: read address 0x0001 (holding 1) with CE1=1 -> Q1=1; then CE1=0 for 3 cycles -> Q1 stays 1; assert RST for 1 cycle -> Q1=0, and a following read returns 1 (contents preserved).
REQ-034 Dual write, same address 0x2000: D0=0, D1=1, both WEM=1 -> stored 1 (port 1 wins); with BRAM_COLLISION_CHECK_EN defined -> error message and $finish.
REQ-035 Address extremes: write 1 to 0x0000 and 0x3FFF, then sweep-read all 16384 addresses -> exactly those two return 1.
